// File: rtl/sobel_grad.sv
// Sobel gradient magnitude on a 3x3 window (centre pixel unused), 3-stage pipeline,
// with thresholded edge flag, matched sync delay and a per-frame edge counter.
module sobel_grad #(
  parameter int THRESH = 128,
  parameter int CNT_W  = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       pix_0,
  input  logic [7:0]       pix_1,
  input  logic [7:0]       pix_2,
  input  logic [7:0]       pix_3,
  input  logic [7:0]       pix_5,
  input  logic [7:0]       pix_6,
  input  logic [7:0]       pix_7,
  input  logic [7:0]       pix_8,
  input  logic             in_valid,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [7:0]       mag,
  output logic             edge_flag,   // "edge" is a reserved word in SystemVerilog
  output logic             out_valid,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [CNT_W-1:0] frame_edges,
  output logic             frame_done
);

  localparam int               STAGES  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0]       THR     = 8'(THRESH);

  typedef struct packed {
    logic hs;
    logic vs;
  } sync_t;

  logic  [STAGES:1] vld_pipe;
  sync_t [STAGES:1] sync_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe  <= '0;
      sync_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:1], in_valid};
      sync_pipe <= {sync_pipe[STAGES-1:1], hsync_in, vsync_in};
    end
  end

  // stage 1: each gradient as difference of two 10-bit unsigned sums (max 1020)
  logic [9:0]         gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx_s1, gy_s1;

  assign gx_pos = 10'(pix_2) + {1'b0, pix_5, 1'b0} + 10'(pix_8);
  assign gx_neg = 10'(pix_0) + {1'b0, pix_3, 1'b0} + 10'(pix_6);
  assign gy_pos = 10'(pix_6) + {1'b0, pix_7, 1'b0} + 10'(pix_8);
  assign gy_neg = 10'(pix_0) + {1'b0, pix_1, 1'b0} + 10'(pix_2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gx_s1 <= '0;
      gy_s1 <= '0;
    end else begin
      gx_s1 <= $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
      gy_s1 <= $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
    end
  end

  // stage 2: magnitudes; |-1020| still fits in 10 bits
  function automatic logic [9:0] abs11(input logic signed [10:0] v);
    return v[10] ? 10'(-v) : v[9:0];
  endfunction

  logic [9:0] ax_s2, ay_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ax_s2 <= '0;
      ay_s2 <= '0;
    end else begin
      ax_s2 <= abs11(gx_s1);
      ay_s2 <= abs11(gy_s1);
    end
  end

  // stage 3: saturate, gate by valid, threshold
  logic [10:0] sum_s2;
  logic [7:0]  sat_s2;

  assign sum_s2 = {1'b0, ax_s2} + {1'b0, ay_s2};
  assign sat_s2 = (sum_s2 > 11'd255) ? 8'hFF : sum_s2[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag       <= '0;
      edge_flag <= 1'b0;
    end else begin
      mag       <= vld_pipe[2] ? sat_s2 : 8'd0;
      edge_flag <= vld_pipe[2] && (sat_s2 >= THR);
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign hsync_out = sync_pipe[STAGES].hs;
  assign vsync_out = sync_pipe[STAGES].vs;

  // frame counter: an edge coincident with the vsync_out fall belongs to the closing frame
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             vs_prev, vs_fall;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(edge_flag);
  assign vs_fall = vs_prev & ~vsync_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      vs_prev     <= 1'b0;
      frame_edges <= '0;
      frame_done  <= 1'b0;
    end else begin
      vs_prev    <= vsync_out;
      frame_done <= vs_fall;
      if (vs_fall) begin
        frame_edges <= cnt_inc;
        cnt         <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_sobel_grad.sv
// Scoreboard bench for sobel_grad: directed windows with hand-computed magnitudes,
// a second instance built with THRESH=40 for the inclusive-threshold boundary.
module tb_sobel_grad;

  localparam int CNT_W = 19;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] pix_0 = '0, pix_1 = '0, pix_2 = '0, pix_3 = '0;
  logic [7:0] pix_5 = '0, pix_6 = '0, pix_7 = '0, pix_8 = '0;
  logic in_valid = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;

  logic [7:0]       mag, mag40;
  logic             edge_flag, edge40, out_valid, valid40;
  logic             hsync_out, vsync_out, hs40, vs40;
  logic [CNT_W-1:0] frame_edges, fe40;
  logic             frame_done, fd40;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sobel_grad #(.THRESH(128), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .pix_0(pix_0), .pix_1(pix_1), .pix_2(pix_2), .pix_3(pix_3),
    .pix_5(pix_5), .pix_6(pix_6), .pix_7(pix_7), .pix_8(pix_8),
    .in_valid(in_valid), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mag(mag), .edge_flag(edge_flag), .out_valid(out_valid),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_edges(frame_edges), .frame_done(frame_done)
  );

  sobel_grad #(.THRESH(40), .CNT_W(CNT_W)) u_t40 (
    .clk(clk), .rst(rst),
    .pix_0(pix_0), .pix_1(pix_1), .pix_2(pix_2), .pix_3(pix_3),
    .pix_5(pix_5), .pix_6(pix_6), .pix_7(pix_7), .pix_8(pix_8),
    .in_valid(in_valid), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mag(mag40), .edge_flag(edge40), .out_valid(valid40),
    .hsync_out(hs40), .vsync_out(vs40),
    .frame_edges(fe40), .frame_done(fd40)
  );

  typedef struct {
    int         due;
    logic [7:0] m;
    logic       e, v, hs, vs, e40;
    logic       chk_fe;
    int         fe;
  } exp_t;

  typedef struct {
    int due;
    int n;
  } fexp_t;

  exp_t  sq[$];
  fexp_t fq[$];
  int    tests  = 0;
  int    failed = 0;
  bit    done   = 1'b0;
  int    cnt_m  = 0;
  logic  prev_vs = 1'b0;

  task automatic drive(input logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8,
                       input logic v, hs, vs, input int emag);
    exp_t  x;
    fexp_t f;
    logic  e;
    @(posedge clk); #1;
    pix_0 = p0; pix_1 = p1; pix_2 = p2; pix_3 = p3;
    pix_5 = p5; pix_6 = p6; pix_7 = p7; pix_8 = p8;
    in_valid = v; hsync_in = hs; vsync_in = vs;
    e = v && (emag >= 128);
    x = '{due: cyc + 3, m: v ? 8'(emag) : 8'd0, e: e, v: v, hs: hs, vs: vs,
          e40: v && (emag >= 40), chk_fe: 1'b0, fe: 0};
    sq.push_back(x);
    if (prev_vs && !vs) begin
      f = '{due: cyc + 4, n: cnt_m + int'(e)};
      fq.push_back(f);
      cnt_m = 0;
    end else begin
      cnt_m += int'(e);
    end
    prev_vs = vs;
  endtask

  task automatic idle(input logic hs, vs);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, hs, vs, 0);
  endtask

  task automatic step(input logic vs);
    drive(0, 0, 255, 0, 255, 0, 0, 255, 1'b1, 1'b1, vs, 255);
  endtask

  task automatic flat(input logic vs);
    drive(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 1'b1, 1'b1, vs, 0);
  endtask

  task automatic do_reset();
    exp_t x;
    @(posedge clk); #1;
    rst = 1'b0;
    sq.delete();
    fq.delete();
    cnt_m   = 0;
    prev_vs = 1'b0;
    x = '{due: cyc, m: 8'd0, e: 1'b0, v: 1'b0, hs: 1'b0, vs: 1'b0, e40: 1'b0,
          chk_fe: 1'b1, fe: 0};
    sq.push_back(x);
    repeat (3) idle(1'b0, 1'b0);
    rst = 1'b1;
  endtask

  exp_t  mx;
  fexp_t mf;
  always @(negedge clk) begin
    if (sq.size() != 0 && sq[0].due < cyc) begin
      tests++; failed++;
      $display("FAIL sb_stale cyc=%0d entry due=%0d never checked", cyc, sq[0].due);
      void'(sq.pop_front());
    end
    if (sq.size() != 0 && sq[0].due == cyc) begin
      mx = sq.pop_front();
      tests++;
      if (mag !== mx.m || edge_flag !== mx.e || out_valid !== mx.v ||
          hsync_out !== mx.hs || vsync_out !== mx.vs || edge40 !== mx.e40 ||
          mag40 !== mx.m || valid40 !== mx.v || hs40 !== mx.hs || vs40 !== mx.vs ||
          (mx.chk_fe && frame_edges !== CNT_W'(mx.fe))) begin
        failed++;
        $display("FAIL pipe_out cyc=%0d got mag=%0d edge=%0b valid=%0b hs=%0b vs=%0b edge40=%0b mag40=%0d fe=%0d want mag=%0d edge=%0b valid=%0b hs=%0b vs=%0b edge40=%0b fe=%0d",
                 cyc, mag, edge_flag, out_valid, hsync_out, vsync_out, edge40, mag40,
                 frame_edges, mx.m, mx.e, mx.v, mx.hs, mx.vs, mx.e40, mx.fe);
      end
    end
    if (fq.size() != 0 && fq[0].due == cyc) begin
      mf = fq.pop_front();
      tests++;
      if (frame_done !== 1'b1 || frame_edges !== CNT_W'(mf.n)) begin
        failed++;
        $display("FAIL frame_latch cyc=%0d got done=%0b edges=%0d want done=1 edges=%0d",
                 cyc, frame_done, frame_edges, mf.n);
      end
    end else begin
      tests++;
      if (frame_done !== 1'b0) begin
        failed++;
        $display("FAIL frame_done_idle cyc=%0d got done=%0b want 0", cyc, frame_done);
      end
    end
    if (done) begin
      tests++;
      if (sq.size() != 0 || fq.size() != 0) begin
        failed++;
        $display("FAIL drain got %0d/%0d pending want 0/0", sq.size(), fq.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    // flat field, then single-window directed vectors
    repeat (4) flat(1'b1);
    step(1'b1);
    drive(0, 0, 10, 0, 10, 0, 0, 10, 1, 1, 1, 40);
    drive(0, 0, 0, 0, 0, 255, 255, 255, 1, 1, 1, 255);
    drive(0, 0, 0, 0, 0, 0, 0, 100, 1, 1, 1, 200);
    drive(30, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 60);
    drive(0, 0, 0, 20, 0, 0, 0, 0, 1, 1, 1, 40);
    drive(0, 64, 0, 0, 0, 0, 0, 0, 1, 1, 1, 128);
    drive(0, 63, 0, 0, 0, 0, 0, 0, 1, 1, 1, 126);
    drive(0, 0, 0, 0, 128, 0, 0, 0, 1, 1, 1, 255);
    drive(0, 0, 0, 0, 127, 0, 0, 0, 1, 1, 1, 254);
    drive(0, 0, 255, 0, 255, 0, 0, 255, 0, 1, 1, 255);
    // hsync pulse, then a vsync pulse closing the directed-vector frame
    idle(1'b0, 1'b1); idle(1'b0, 1'b1); idle(1'b1, 1'b1);
    idle(1'b1, 1'b0); idle(1'b1, 1'b0); idle(1'b1, 1'b1);
    // ten edges, the last coincident with the vsync fall
    repeat (9) step(1'b1);
    step(1'b0);
    idle(1'b1, 1'b0); idle(1'b1, 1'b0); idle(1'b1, 1'b1);
    // frame with no edges
    repeat (4) flat(1'b1);
    flat(1'b0);
    idle(1'b1, 1'b0); idle(1'b1, 1'b1);
    // reset mid-frame after 5 edges, then 3 edges and a vsync
    repeat (5) step(1'b1);
    do_reset();
    repeat (3) step(1'b1);
    idle(1'b1, 1'b1); idle(1'b1, 1'b1);
    idle(1'b1, 1'b0); idle(1'b1, 1'b0); idle(1'b1, 1'b1);
    repeat (6) @(posedge clk);
    done = 1'b1;
  end

endmodule
